// File: rtl/alarm_clk_seg_pkg.sv
// Shared constants for the alarm clock 7-segment effects stage:
// register addresses, CTRL bit positions and field widths.
package alarm_clk_seg_pkg;

    localparam int SEG_W    = 7;
    localparam int HALF_W   = 16;
    localparam int BRIGHT_W = 4;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_HALF   = 2'd1;
    localparam logic [1:0] ADDR_BRIGHT = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_BLINK  = 0;
    localparam int CTRL_BLANK  = 1;
    localparam int CTRL_INVERT = 2;

endpackage

// File: rtl/alarm_clk_seg_if.sv
// Avalon-MM slave bus bundle for the segment effects stage.
// Signals: address, chipselect, write_n, writedata (CPU side), readdata (slave side).
interface alarm_clk_seg_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/alarm_clk_tick_gen.sv
// Free-running prescaler: counts 0..TICK_DIV-1 and emits a one-cycle tick on the last count.
// Ports: clk, reset_n (sync, active-low), tick (output pulse).
module alarm_clk_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alarm_clk_seg_fx.sv
// Display effects for one 7-segment digit: blink, PWM brightness, blanking, polarity.
// Ports: clk, reset_n (sync, active-low), seg_in, bus (Avalon slave), seg_out (registered pins).
module alarm_clk_seg_fx
    import alarm_clk_seg_pkg::*;
#(
    parameter int TICK_DIV   = 50000,
    parameter bit INVERT_RST = 1'b1,
    parameter int HALF_RST   = 500
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [SEG_W-1:0] seg_in,
    alarm_clk_seg_if.slave   bus,
    output logic [SEG_W-1:0] seg_out
);

    localparam logic [HALF_W-1:0] HALF_INIT = HALF_W'(HALF_RST);

    logic                blink_en;
    logic                force_blank;
    logic                invert;
    logic [HALF_W-1:0]   half;
    logic [BRIGHT_W-1:0] bright;
    logic [HALF_W-1:0]   bcnt;
    logic                phase;
    logic [BRIGHT_W-1:0] pcnt;

    logic tick;
    logic wr, wr_ctrl, wr_half, wr_bright;
    logic restart, blink_run, pwm_on, visible;
    logic unused_wdata;

    alarm_clk_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    assign wr        = bus.chipselect & ~bus.write_n;
    assign wr_ctrl   = wr & (bus.address == ADDR_CTRL);
    assign wr_half   = wr & (bus.address == ADDR_HALF);
    assign wr_bright = wr & (bus.address == ADDR_BRIGHT);

    // Restarting on a blink_en change keeps the digit shown right after toggling blink.
    assign restart   = wr_half
                     | (wr_ctrl & (bus.writedata[CTRL_BLINK] != blink_en));
    assign blink_run = blink_en & (half != '0);
    assign pwm_on    = (pcnt <= bright);
    assign visible   = ~force_blank & pwm_on & phase;

    assign unused_wdata = ^bus.writedata[31:HALF_W];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            blink_en    <= 1'b0;
            force_blank <= 1'b0;
            invert      <= INVERT_RST;
            half        <= HALF_INIT;
            bright      <= '1;
        end else begin
            if (wr_ctrl) begin
                blink_en    <= bus.writedata[CTRL_BLINK];
                force_blank <= bus.writedata[CTRL_BLANK];
                invert      <= bus.writedata[CTRL_INVERT];
            end
            if (wr_half) begin
                half <= bus.writedata[HALF_W-1:0];
            end
            if (wr_bright) begin
                bright <= bus.writedata[BRIGHT_W-1:0];
            end
        end
    end

    // A CPU restart takes priority over a coincident tick.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bcnt  <= '0;
            phase <= 1'b1;
        end else if (restart || !blink_run) begin
            bcnt  <= '0;
            phase <= 1'b1;
        end else if (tick) begin
            if (bcnt == half - 1'b1) begin
                bcnt  <= '0;
                phase <= ~phase;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pcnt    <= '0;
            seg_out <= {SEG_W{INVERT_RST}};
        end else begin
            pcnt    <= pcnt + 1'b1;
            seg_out <= (visible ? seg_in : '0) ^ {SEG_W{invert}};
        end
    end

    always_comb begin
        bus.readdata = '0;
        unique case (bus.address)
            ADDR_CTRL:   bus.readdata[2:0] = {invert, force_blank, blink_en};
            ADDR_HALF:   bus.readdata[HALF_W-1:0] = half;
            ADDR_BRIGHT: bus.readdata[BRIGHT_W-1:0] = bright;
            ADDR_STATUS: bus.readdata[1:0] = {visible, phase};
        endcase
    end

endmodule

// File: tb/tb_alarm_clk_seg_fx.sv
// Scoreboard bench for alarm_clk_seg_fx: stimulus queues expectations,
// a negedge monitor pops and checks seg_out / readdata.
module tb_alarm_clk_seg_fx;

    localparam int TB_DIV = 4;

    localparam int K_SEG = 0;
    localparam int K_RD  = 1;
    localparam int K_WIN = 2;
    localparam int K_RUN = 3;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
        logic [6:0]  pat;
        int          n;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic [6:0] seg_in;
    logic [6:0] seg_out;

    alarm_clk_seg_if bus ();

    alarm_clk_seg_fx #(
        .TICK_DIV   (TB_DIV),
        .INVERT_RST (1'b1),
        .HALF_RST   (500)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .seg_in  (seg_in),
        .bus     (bus),
        .seg_out (seg_out)
    );

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   busy = 0;
    int   mcnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference prescaler phase, used only to time the tick-collision write.
    always @(posedge clk) begin
        if (!reset_n) mcnt <= 0;
        else mcnt <= (mcnt == TB_DIV - 1) ? 0 : mcnt + 1;
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 300 && (sb.size() != 0 || busy); i++) step(1);
        if (sb.size() != 0 || busy) begin
            checks++;
            errors++;
            $display("FAIL drain: monitor timeout, %0d pending", sb.size());
            sb.delete();
        end
    endtask

    task automatic push(string nm, int k, logic [31:0] x, logic [6:0] p, int w);
        exp_t e;
        e.name = nm;
        e.kind = k;
        e.exp  = x;
        e.pat  = p;
        e.n    = w;
        sb.push_back(e);
        drain();
    endtask

    task automatic exp_seg(string nm, logic [6:0] x);
        push(nm, K_SEG, {25'd0, x}, 7'h00, 0);
    endtask

    task automatic exp_rd(string nm, logic [1:0] a, logic [31:0] x);
        bus.address = a;
        push(nm, K_RD, x, 7'h00, 0);
    endtask

    task automatic bus_write(logic [1:0] a, logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        step(1);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        int   cnt;
        bit   started, done;
        logic [6:0] prev;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                busy = 1;
                e = sb.pop_front();
                case (e.kind)
                    K_SEG: check(e.name, {25'd0, seg_out}, e.exp);
                    K_RD:  check(e.name, bus.readdata, e.exp);
                    K_WIN: begin
                        cnt = 0;
                        for (int i = 0; i < e.n; i++) begin
                            if (i > 0) @(negedge clk);
                            if (seg_out == e.pat) cnt++;
                        end
                        check(e.name, cnt, e.exp);
                    end
                    default: begin
                        cnt = 0;
                        started = 0;
                        done = 0;
                        prev = e.pat;
                        for (int i = 0; i < 150 && !done; i++) begin
                            if (i > 0) @(negedge clk);
                            if (!started) begin
                                if (seg_out == e.pat && prev != e.pat) begin
                                    started = 1;
                                    cnt = 1;
                                end
                            end else if (seg_out == e.pat) begin
                                cnt++;
                            end else begin
                                done = 1;
                            end
                            prev = seg_out;
                        end
                        if (!done) cnt = -1;
                        check(e.name, cnt, e.exp);
                    end
                endcase
                busy = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int ticks;
        reset_n        = 1'b0;
        seg_in         = 7'h3F;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;

        // Reset defaults
        step(2);
        exp_seg("rst_dark", 7'h7F);
        reset_n = 1'b1;
        step(1);
        exp_seg("post_rst", 7'h40);
        exp_rd("rst_status", 2'd3, 32'd3);
        exp_rd("rst_ctrl", 2'd0, 32'd4);
        exp_rd("rst_half", 2'd1, 32'd500);
        exp_rd("rst_bright", 2'd2, 32'd15);

        // Polarity and latency
        bus_write(2'd0, 32'd0);
        seg_in = 7'h06;
        step(1);
        exp_seg("noinv_06", 7'h06);
        seg_in = 7'h5B;
        step(1);
        exp_seg("lat1_5b", 7'h5B);
        bus_write(2'd0, 32'd2);
        step(1);
        exp_seg("force_blank", 7'h00);
        bus_write(2'd0, 32'd0);
        seg_in = 7'h06;

        // PWM duty
        bus_write(2'd2, 32'hFFFF_FFF3);
        exp_rd("bright_mask", 2'd2, 32'd3);
        step(1);
        push("duty_b3", K_WIN, 32'd4, 7'h06, 16);
        bus_write(2'd2, 32'd0);
        step(1);
        push("duty_b0", K_WIN, 32'd1, 7'h06, 16);
        bus_write(2'd2, 32'd15);
        step(1);
        push("duty_b15", K_WIN, 32'd16, 7'h06, 16);

        // Blink timing: 3 ticks x 4 clk = 12 clk per half period
        bus_write(2'd1, 32'd3);
        bus_write(2'd0, 32'd1);
        push("blink_lit_run", K_RUN, 32'd12, 7'h06, 0);
        push("blink_dark_run", K_RUN, 32'd12, 7'h00, 0);
        push("blink_lit_run2", K_RUN, 32'd12, 7'h06, 0);
        bus_write(2'd1, 32'd3);
        step(1);
        exp_seg("half_restart", 7'h06);
        exp_rd("restart_status", 2'd3, 32'd3);

        // HALF = 0 with blink enabled
        bus_write(2'd1, 32'd0);
        step(1);
        push("half0_visible", K_WIN, 32'd16, 7'h06, 16);

        // HALF write coinciding with the terminal tick
        bus_write(2'd1, 32'd3);
        ticks = 0;
        for (int i = 0; i < 100; i++) begin
            if (mcnt == TB_DIV - 1) begin
                if (ticks == 2) break;
                ticks++;
            end
            step(1);
        end
        bus_write(2'd1, 32'd3);
        step(1);
        push("collide_no_toggle", K_WIN, 32'd8, 7'h06, 8);

        // Reset mid-blink just after entering the dark half
        push("pre_rst_lit_run", K_RUN, 32'd12, 7'h06, 0);
        bus.address = 2'd0;
        reset_n = 1'b0;
        step(1);
        exp_seg("mid_rst_dark", 7'h7F);
        seg_in = 7'h3F;
        reset_n = 1'b1;
        step(1);
        exp_seg("mid_post_rst", 7'h40);
        exp_rd("mid_rst_ctrl", 2'd0, 32'd4);
        exp_rd("mid_rst_half", 2'd1, 32'd500);
        exp_rd("mid_rst_status", 2'd3, 32'd3);

        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_clk_seg_fx.md
Name: alarm_clk_seg_fx

Overview:
Downstream display-effects stage for one 7-segment digit of the alarm clock.
- Consumes the 7-bit segment pattern produced by a digit output port (e.g. the hours-units digit, H0).
- Applies blink (alarm or setting mode), PWM brightness, forced blanking and output polarity before driving the physical segment pins.
- Configured by the Nios CPU through a small Avalon-MM slave with zero-wait-state reads.

Parameters:
TICK_DIV, 50000, clk cycles per blink tick (1 ms at 50 MHz); legal range 2..2^20.
INVERT_RST, 1, reset value of ctrl.invert (board segments are active-low).
HALF_RST, 500, reset value of the blink half-period register, in ticks.

Ports:
clk  input  1  system clock; the only clock.
reset_n  input  1  synchronous, active-low reset.
seg_in  input  7  segment pattern from the upstream digit port, active-high, bit0 = segment a.
address  input  2  Avalon register select.
chipselect  input  1  Avalon chip select.
write_n  input  1  Avalon write strobe, active-low.
writedata  input  32  Avalon write data.
readdata  output  32  Avalon read data, combinational, unused bits 0.
seg_out  output  7  segment pins to the display, polarity per ctrl.invert.

Behaviour:
Interface:
- One clock, `clk`.
- Reset is `reset_n`, synchronous and active-low: all state updates on the `clk` edge where `reset_n == 0`.

Register map (write = chipselect & ~write_n):
- 0 CTRL: bit0 blink_en, bit1 force_blank, bit2 invert. Reset 0, 0, INVERT_RST.
- 1 HALF: bits[15:0], blink half-period in ticks. Reset HALF_RST.
- 2 BRIGHT: bits[3:0]. Reset 15.
- 3 STATUS (read-only): bit0 phase, bit1 visible. Writes are ignored.

Reads:
- readdata is a combinational mux of address; no wait states.
- Reads have no side effects.

Prescaler:
- Counter counts 0..TICK_DIV-1 and wraps.
- tick is a 1-cycle pulse on the cycle the counter equals TICK_DIV-1.

Blink:
- Counter bcnt[15:0] and phase bit; phase = 1 means the digit is shown.
- If blink_en = 0 or HALF = 0: bcnt is held at 0 and phase is held at 1.
- Otherwise, on each tick:
  - if bcnt == HALF-1: bcnt <= 0 and phase toggles;
  - else bcnt increments.
- Any write to HALF, or a write to CTRL that changes blink_en, sets bcnt = 0 and phase = 1 on the next edge. The prescaler is not reset.

PWM:
- 4-bit free-running counter pcnt, incremented every clk.
- pwm_on = (pcnt <= BRIGHT).
- BRIGHT = 15 gives always on; BRIGHT = 0 gives a 1/16 duty cycle.

Output:
- visible = ~force_blank & pwm_on & phase.
- seg_out is registered: seg_out <= (visible ? seg_in : 7'h00) ^ {7{invert}}.
- Latency from seg_in, or from any register write, to seg_out is 1 cycle.
- Reset value of seg_out = {7{INVERT_RST}}, i.e. all segments dark.

Simultaneous events:
- A CPU write and a tick on the same cycle: the write's clear of bcnt/phase wins.

Reset mid-operation:
- All counters return to 0, phase to 1, registers to their reset values, and seg_out to the dark pattern.
- Behaviour on the first cycle after reset_n rises is identical to power-up.

Decomposition:
Package alarm_clk_seg_pkg:
- register address constants ADDR_CTRL, ADDR_HALF, ADDR_BRIGHT, ADDR_STATUS;
- CTRL bit indices;
- SEG_W = 7.

Sub-module alarm_clk_tick_gen (parameter TICK_DIV; ports clk, reset_n, tick). It is natural to split out because it will be reused by the seconds counter and the buzzer.

Test Plan:
1. Reset defaults: reset_n = 0 for 2 cycles, then release, seg_in = 7'h3F → seg_out = 7'h7F during reset, 7'h40 one cycle after release; STATUS reads 3.
2. Polarity and latency: write CTRL = 0, seg_in 7'h06 → seg_out = 7'h06 exactly 1 cycle later; force_blank = 1 → seg_out = 7'h00.
3. Blink timing: TICK_DIV = 4, HALF = 3, CTRL = 1 → phase toggles every 12 clk; seg_out alternates between seg_in and dark (inverted per ctrl.invert); a HALF write mid-period restarts with phase = 1.
4. PWM duty: BRIGHT = 3, blink off → seg_out shows seg_in on 4 of every 16 cycles; BRIGHT = 15 → always; BRIGHT = 0 → 1 of 16.
5. Edge cases: HALF = 0 with blink_en = 1 → always visible; a HALF write on the same cycle as the terminal tick → bcnt = 0, phase = 1, no toggle.
6. Reset mid-blink while phase = 0 → after release, phase = 1, registers back to defaults, seg_out dark during reset.
